param_counter_sched: RTL and testbench
======================================

# param_counter_sched

Time-slice scheduler that shares one free-running modulo counter among NREQ requesters. Each requester asks for an interval of `len` counter ticks. The block grants the counter to one requester at a time, gates the counter enable, measures elapsed ticks against a start snapshot, and signals completion or abort. It sits between the requesting blocks and a single counter instance, and is the only driver of that counter's enable.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `MOD`, default 65536: counter modulus. Must be a power of two. `W = $clog2(MOD)`.
- `clk` input, 1: clock.
- `rst_` input, 1: reset, asynchronous, active-low.
- `req` input, NREQ: per-requester request level. Must be held until `done` or `abort`.
- `len` input, NREQ*W: requested interval per requester. Slice i is `len[i*W +: W]`, sampled at grant.
- `cnt_q` input, W: current value of the shared counter, which wraps modulo 2^W.
- `cnt_en` output, 1: enable to the shared counter.
- `grant` output, NREQ: one-hot grant, registered.
- `done` output, NREQ: one-cycle pulse on the granted bit when the interval completes.
- `abort` output, NREQ: one-cycle pulse on the granted bit when the requester withdraws early.
- `busy` output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, DONE, ABORT.
- **IDLE**
  - If any `req` bit is set, select a winner g and go to RUN.
  - On the transition: `grant <= onehot(g)`, `base <= cnt_q`, `len_l <= len slice g`, `last <= g`.
- **Winner selection (round-robin)**
  - Search starts at `last+1` and proceeds ascending, wrapping at NREQ.
  - `last` resets to NREQ-1, so req[0] wins first after reset.
- **RUN**
  - `elapsed = (cnt_q - base)` truncated to W bits, so wrap of the counter through 0 is handled.
  - `cnt_en = (state==RUN) && (elapsed != len_l) && req[g]`. This is combinational, so the counter stops exactly at `len_l`.
  - If `req[g]==0`, go to ABORT. This takes priority over completion in the same cycle.
  - Else if `elapsed == len_l`, go to DONE.
  - `grant` clears on either transition.
- **DONE**: `done[g]=1` for exactly one cycle, then IDLE.
- **ABORT**: `abort[g]=1` for exactly one cycle, then IDLE.
- **Zero length**: `len_l==0` completes without asserting `cnt_en`.
- **Maximum length**: `len_l = 2^W-1` is legal. `len_l` cannot encode 2^W.
- **No preemption**: new requests from other indices are ignored until IDLE.
- Requests that appear while the FSM is in DONE or ABORT are arbitrated in the following IDLE cycle.
- **Reset mid-operation**: the FSM returns to IDLE and `last` returns to NREQ-1. The interval is lost and no done/abort pulse is produced.
- The controller never writes or clears the counter. Correctness relies only on modulo subtraction from `base`.

## Timing
- **Reset values**: `grant=0`, `done=0`, `abort=0`, `busy=0`, `cnt_en=0`.
- **Edge numbering**: req first sampled high in IDLE at edge E0.
- **After E0**: `grant` and `busy` are high.
- **Counter enable**: `cnt_en` is high from E0 until elapsed reaches `len_l`. The counter increments at edges E1..E_len.
- **Completion**: at E_{len+1}, `grant` goes low and `done` goes high. At E_{len+2}, the FSM is in IDLE and `busy` is low.
- **Next grant**: the earliest next grant is visible after E_{len+3}.
- **Slot length**: `grant` is high for len+1 cycles. A full slot, request to idle, is len+3 cycles.
- **Abort latency**: req dropped in cycle C (RUN) gives `abort` in cycle C+1 and `grant` low in cycle C+1. `cnt_en` drops in cycle C, because it is combinational on req.
- **Simultaneous requests in IDLE**: exactly one grant, chosen by round-robin from `last`.

## Configuration
- Macro: `PARAM_COUNTER_SCHED_PRIO_EN`.
- **Defined**: fixed priority. The lowest index with `req` set wins. `last` is unused.
- **Undefined**: round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- **Single request**: NREQ=4, W=16. req[2]=1 with len=5 and cnt_q=100 at E0. Expect grant=4'b0100 after E0, cnt_en high for 5 cycles, cnt_q=105, done=4'b0100 for one cycle at E6, busy low after E7.
- **Counter wrap**: base cnt_q=65533 with len=6. Expect done when cnt_q=3, with exactly 6 cnt_en cycles.
- **Round-robin fairness**: req=4'b1111 held and len=0 for all. Expect grant order 0,1,2,3,0, with one done per slot, 3 cycles apart. With the macro defined, expect repeated grants to 0 only.
- **Abort**: req[1] granted with len=10, dropped after 3 counts. Expect abort=4'b0010 for one cycle, no done, cnt_q advanced by exactly 3.
- **Simultaneous abort and completion**: req drops in the same cycle elapsed==len_l. Expect abort, not done.
- **Reset mid-RUN**: rst_ pulsed low during RUN. Expect all outputs 0 immediately, no pulses afterwards, and the next grant to req[0] when all requests are high.

Source files
------------

// File: rtl/param_counter_sched.sv
// Time-slice scheduler: grants one shared free-running modulo counter to one of NREQ requesters at a time.
// Build option: define PARAM_COUNTER_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module param_counter_sched #(
  parameter int NREQ = 4,
  parameter int MOD  = 65536,
  localparam int W   = $clog2(MOD)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic [W-1:0]      cnt_q,
  output logic              cnt_en,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   abort,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [NREQ-1:0]   grant_reg;
  logic [NREQ-1:0]   done_reg;
  logic [NREQ-1:0]   abort_reg;
  logic [IW-1:0]     g_reg;
  logic [W-1:0]      base_reg;
  logic [W-1:0]      len_reg;
  logic [W-1:0]      elapsed;
  logic [W-1:0]      len_arr [NREQ];
  logic [IW-1:0]     cand_idx [NREQ];
  logic [NREQ-1:0]   cand_req;
  logic [IW-1:0]     win_idx;
  logic              any_req;

`ifndef PARAM_COUNTER_SCHED_PRIO_EN
  logic [IW-1:0]     last_reg;
`endif

  // cand_idx[k] is the k-th requester in search order; slot 0 has the highest priority.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign len_arr[gi] = len[gi*W +: W];
`ifdef PARAM_COUNTER_SCHED_PRIO_EN
      assign cand_idx[gi] = IW'(gi);
`else
      logic [IW:0] sum;
      assign sum = {1'b0, last_reg} + (IW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
`endif
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        win_idx = cand_idx[i];
      end
    end
  end

  assign any_req = |req;

  // Modulo subtraction keeps the interval correct across counter wrap.
  assign elapsed = cnt_q - base_reg;
  assign cnt_en  = (state_reg == RUN) && (elapsed != len_reg) && req[g_reg];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Withdrawal wins over completion in the same cycle.
        if (!req[g_reg]) begin
          state_next = ABORT;
        end else if (elapsed == len_reg) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      done_reg  <= '0;
      abort_reg <= '0;
      g_reg     <= '0;
      base_reg  <= '0;
      len_reg   <= '0;
`ifndef PARAM_COUNTER_SCHED_PRIO_EN
      last_reg  <= IW'(NREQ - 1);
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= '0;
      abort_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg <= NREQ'(1) << win_idx;
            base_reg  <= cnt_q;
            len_reg   <= len_arr[win_idx];
            g_reg     <= win_idx;
`ifndef PARAM_COUNTER_SCHED_PRIO_EN
            last_reg  <= win_idx;
`endif
          end
        end
        RUN: begin
          if (state_next == ABORT) begin
            grant_reg <= '0;
            abort_reg <= grant_reg;
          end else if (state_next == DONE) begin
            grant_reg <= '0;
            done_reg  <= grant_reg;
          end
        end
        default: begin
          grant_reg <= '0;
        end
      endcase
    end
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign abort = abort_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_param_counter_sched.sv
// Directed self-checking bench for param_counter_sched (NREQ=4, 16-bit counter modelled in the bench).
// Honours PARAM_COUNTER_SCHED_PRIO_EN for the arbitration-order expectations.
module tb_param_counter_sched;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [63:0] len = 64'b0;
  logic [15:0] cnt_q = 16'd0;
  logic        cnt_en;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  abort;
  logic        busy;

  logic        load_en = 1'b0;
  logic [15:0] load_val = 16'd0;
  int          en_total = 0;
  int          done_total = 0;
  int          abort_total = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  param_counter_sched #(.NREQ(4), .MOD(65536)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .req    (req),
    .len    (len),
    .cnt_q  (cnt_q),
    .cnt_en (cnt_en),
    .grant  (grant),
    .done   (done),
    .abort  (abort),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Shared counter: loadable by the bench, otherwise counts when enabled.
  always @(posedge clk) begin
    if (load_en) cnt_q <= load_val;
    else if (cnt_en) cnt_q <= cnt_q + 16'd1;
  end

  always @(posedge clk) begin
    if (cnt_en) en_total++;
    if (|done) done_total++;
    if (|abort) abort_total++;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task load_cnt(input logic [15:0] v);
    load_val = v;
    load_en = 1'b1;
    tick;
    load_en = 1'b0;
  endtask

  task test_reset;
    rst_ = 1'b0;
    load_cnt(16'd0);
    tick;
    if (grant !== 4'b0) begin $display("FAIL reset_grant: got %b want %b", grant, 4'b0); n_bad++; end n_cmp++;
    if (done !== 4'b0) begin $display("FAIL reset_done: got %b want %b", done, 4'b0); n_bad++; end n_cmp++;
    if (abort !== 4'b0) begin $display("FAIL reset_abort: got %b want %b", abort, 4'b0); n_bad++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_bad++; end n_cmp++;
    if (cnt_en !== 1'b0) begin $display("FAIL reset_cnt_en: got %b want 0", cnt_en); n_bad++; end n_cmp++;
    rst_ = 1'b1;
    tick;
    $display("reset: grant=%b busy=%b cnt_en=%b", grant, busy, cnt_en);
  endtask

  task test_round_robin;
    logic [3:0] exp_g [5];
    int e0, d0;
`ifdef PARAM_COUNTER_SCHED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    len = 64'b0;
    e0 = en_total;
    d0 = done_total;
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick;
      if (grant !== exp_g[s]) begin $display("FAIL rr_grant slot %0d: got %b want %b", s, grant, exp_g[s]); n_bad++; end n_cmp++;
      if (cnt_en !== 1'b0) begin $display("FAIL rr_zero_len_en slot %0d: got %b want 0", s, cnt_en); n_bad++; end n_cmp++;
      tick;
      if (done !== exp_g[s]) begin $display("FAIL rr_done slot %0d: got %b want %b", s, done, exp_g[s]); n_bad++; end n_cmp++;
      if (grant !== 4'b0) begin $display("FAIL rr_grant_clear slot %0d: got %b want 0000", s, grant); n_bad++; end n_cmp++;
      tick;
      if (busy !== 1'b0) begin $display("FAIL rr_idle slot %0d: got busy=%b want 0", s, busy); n_bad++; end n_cmp++;
      if (s == 4) req = 4'b0;
      $display("round_robin: slot %0d granted %b", s, exp_g[s]);
    end
    if (en_total - e0 != 0) begin $display("FAIL rr_en_cycles: got %0d want 0", en_total - e0); n_bad++; end n_cmp++;
    if (done_total - d0 != 5) begin $display("FAIL rr_done_count: got %0d want 5", done_total - d0); n_bad++; end n_cmp++;
  endtask

  task test_single;
    int e0;
    load_cnt(16'd100);
    len[2*16 +: 16] = 16'd5;
    e0 = en_total;
    req = 4'b0100;
    tick;
    if (grant !== 4'b0100) begin $display("FAIL single_grant: got %b want 0100", grant); n_bad++; end n_cmp++;
    if (busy !== 1'b1) begin $display("FAIL single_busy: got %b want 1", busy); n_bad++; end n_cmp++;
    if (cnt_en !== 1'b1) begin $display("FAIL single_cnt_en: got %b want 1", cnt_en); n_bad++; end n_cmp++;
    repeat (5) tick;
    if (cnt_q !== 16'd105) begin $display("FAIL single_cnt_q: got %0d want 105", cnt_q); n_bad++; end n_cmp++;
    if (cnt_en !== 1'b0) begin $display("FAIL single_cnt_en_stop: got %b want 0", cnt_en); n_bad++; end n_cmp++;
    if (grant !== 4'b0100) begin $display("FAIL single_grant_hold: got %b want 0100", grant); n_bad++; end n_cmp++;
    tick;
    if (done !== 4'b0100) begin $display("FAIL single_done: got %b want 0100", done); n_bad++; end n_cmp++;
    if (grant !== 4'b0) begin $display("FAIL single_grant_clear: got %b want 0000", grant); n_bad++; end n_cmp++;
    req = 4'b0;
    tick;
    if (done !== 4'b0) begin $display("FAIL single_done_pulse: got %b want 0000", done); n_bad++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL single_idle: got %b want 0", busy); n_bad++; end n_cmp++;
    if (en_total - e0 != 5) begin $display("FAIL single_en_cycles: got %0d want 5", en_total - e0); n_bad++; end n_cmp++;
    $display("single: req[2] len=5 base=100 end cnt_q=%0d", cnt_q);
  endtask

  task test_wrap;
    int e0;
    load_cnt(16'd65533);
    len[0 +: 16] = 16'd6;
    e0 = en_total;
    req = 4'b0001;
    tick;
    if (grant !== 4'b0001) begin $display("FAIL wrap_grant: got %b want 0001", grant); n_bad++; end n_cmp++;
    repeat (6) tick;
    if (cnt_q !== 16'd3) begin $display("FAIL wrap_cnt_q: got %0d want 3", cnt_q); n_bad++; end n_cmp++;
    if (cnt_en !== 1'b0) begin $display("FAIL wrap_cnt_en_stop: got %b want 0", cnt_en); n_bad++; end n_cmp++;
    tick;
    if (done !== 4'b0001) begin $display("FAIL wrap_done: got %b want 0001", done); n_bad++; end n_cmp++;
    req = 4'b0;
    tick;
    if (busy !== 1'b0) begin $display("FAIL wrap_idle: got %b want 0", busy); n_bad++; end n_cmp++;
    if (en_total - e0 != 6) begin $display("FAIL wrap_en_cycles: got %0d want 6", en_total - e0); n_bad++; end n_cmp++;
    $display("wrap: req[0] len=6 base=65533 end cnt_q=%0d", cnt_q);
  endtask

  task test_abort;
    int e0, d0;
    load_cnt(16'd500);
    len[1*16 +: 16] = 16'd10;
    e0 = en_total;
    d0 = done_total;
    req = 4'b0010;
    tick;
    if (grant !== 4'b0010) begin $display("FAIL abort_grant: got %b want 0010", grant); n_bad++; end n_cmp++;
    repeat (3) tick;
    if (cnt_q !== 16'd503) begin $display("FAIL abort_cnt_mid: got %0d want 503", cnt_q); n_bad++; end n_cmp++;
    if (cnt_en !== 1'b1) begin $display("FAIL abort_cnt_en_run: got %b want 1", cnt_en); n_bad++; end n_cmp++;
    req = 4'b0;
    #1;
    if (cnt_en !== 1'b0) begin $display("FAIL abort_cnt_en_drop: got %b want 0", cnt_en); n_bad++; end n_cmp++;
    tick;
    if (abort !== 4'b0010) begin $display("FAIL abort_pulse: got %b want 0010", abort); n_bad++; end n_cmp++;
    if (grant !== 4'b0) begin $display("FAIL abort_grant_clear: got %b want 0000", grant); n_bad++; end n_cmp++;
    if (done !== 4'b0) begin $display("FAIL abort_no_done: got %b want 0000", done); n_bad++; end n_cmp++;
    tick;
    if (abort !== 4'b0) begin $display("FAIL abort_pulse_len: got %b want 0000", abort); n_bad++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL abort_idle: got %b want 0", busy); n_bad++; end n_cmp++;
    if (cnt_q !== 16'd503) begin $display("FAIL abort_cnt_final: got %0d want 503", cnt_q); n_bad++; end n_cmp++;
    if (en_total - e0 != 3) begin $display("FAIL abort_en_cycles: got %0d want 3", en_total - e0); n_bad++; end n_cmp++;
    if (done_total - d0 != 0) begin $display("FAIL abort_done_count: got %0d want 0", done_total - d0); n_bad++; end n_cmp++;
    $display("abort: req[1] len=10 dropped after 3 counts, cnt_q=%0d", cnt_q);
  endtask

  task test_abort_vs_done;
    int d0, a0;
    load_cnt(16'd0);
    len[3*16 +: 16] = 16'd2;
    d0 = done_total;
    a0 = abort_total;
    req = 4'b1000;
    tick;
    if (grant !== 4'b1000) begin $display("FAIL race_grant: got %b want 1000", grant); n_bad++; end n_cmp++;
    repeat (2) tick;
    if (cnt_q !== 16'd2) begin $display("FAIL race_cnt_q: got %0d want 2", cnt_q); n_bad++; end n_cmp++;
    req = 4'b0;
    tick;
    if (abort !== 4'b1000) begin $display("FAIL race_abort: got %b want 1000", abort); n_bad++; end n_cmp++;
    if (done !== 4'b0) begin $display("FAIL race_no_done: got %b want 0000", done); n_bad++; end n_cmp++;
    tick;
    if (busy !== 1'b0) begin $display("FAIL race_idle: got %b want 0", busy); n_bad++; end n_cmp++;
    if (done_total - d0 != 0) begin $display("FAIL race_done_count: got %0d want 0", done_total - d0); n_bad++; end n_cmp++;
    if (abort_total - a0 != 1) begin $display("FAIL race_abort_count: got %0d want 1", abort_total - a0); n_bad++; end n_cmp++;
    $display("abort_vs_done: req[3] dropped as elapsed reached len=2");
  endtask

  task test_reset_mid_run;
    int d0, a0;
    len = {16'd8, 16'd8, 16'd8, 16'd8};
    load_cnt(16'd0);
    req = 4'b0100;
    tick;
    if (grant !== 4'b0100) begin $display("FAIL rmr_first_grant: got %b want 0100", grant); n_bad++; end n_cmp++;
    repeat (2) tick;
    req = 4'b1111;
    #2;
    rst_ = 1'b0;
    #1;
    if (grant !== 4'b0) begin $display("FAIL rmr_grant: got %b want 0000", grant); n_bad++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL rmr_busy: got %b want 0", busy); n_bad++; end n_cmp++;
    if (cnt_en !== 1'b0) begin $display("FAIL rmr_cnt_en: got %b want 0", cnt_en); n_bad++; end n_cmp++;
    if ((done | abort) !== 4'b0) begin $display("FAIL rmr_pulses: got done=%b abort=%b want 0000", done, abort); n_bad++; end n_cmp++;
    d0 = done_total;
    a0 = abort_total;
    repeat (2) tick;
    rst_ = 1'b1;
    tick;
    if (grant !== 4'b0001) begin $display("FAIL rmr_regrant: got %b want 0001", grant); n_bad++; end n_cmp++;
    repeat (2) tick;
    if ((done_total - d0) + (abort_total - a0) != 0) begin
      $display("FAIL rmr_no_pulse: got %0d pulses want 0", (done_total - d0) + (abort_total - a0)); n_bad++;
    end n_cmp++;
    req = 4'b0;
    tick;
    if (abort !== 4'b0001) begin $display("FAIL rmr_abort: got %b want 0001", abort); n_bad++; end n_cmp++;
    tick;
    if (busy !== 1'b0) begin $display("FAIL rmr_idle: got %b want 0", busy); n_bad++; end n_cmp++;
    $display("reset_mid_run: regrant after reset went to req[0]");
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_wrap;
    test_abort;
    test_abort_vs_done;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
